mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the RV32I pipeline. It consumes the decoded memory control bits (mem_read, mem_write, funct3) and the ALU-computed address carried in the EX/MEM register. It runs a request/response handshake with the data cache, stalling the pipeline until the access completes, and returns an aligned, sign- or zero-extended load value to the writeback path. It also checks alignment and legality and, after an optional response timeout, flags a fault.

## Interface
- TIMEOUT, default 0, maximum cycles spent in REQ before timeout asserts; 0 disables the watchdog.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- op_valid  in  1  EX/MEM register holds a valid instruction.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  loads: lb 000, lh 001, lw 010, lbu 100, lhu 101; stores: sb 000, sh 001, sw 010.
- addr  in  32  byte address from the ALU.
- store_data  in  32  rs2 value.
- stall  out  1  hold all pipeline registers.
- done  out  1  access completed; load_data is valid this cycle.
- load_data  out  32  extended load result; holds its value until the next completion.
- fault  out  1  misaligned or illegal access; no memory request is issued.
- timeout  out  1  sticky watchdog flag.
- dmem_read / dmem_write  out  1  registered cache request strobes.
- dmem_address  out  32  {addr[31:2], 2'b00}, registered.
- dmem_wdata  out  32  lane-replicated store data, registered.
- dmem_mbe  out  4  byte enables, registered.
- dmem_resp  in  1  cache completion pulse.
- dmem_rdata  in  32  cache read data, valid with dmem_resp.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Request condition: op_valid & (mem_read | mem_write).
- Fault conditions:
  - mem_read & mem_write both set.
  - Illegal funct3: load 011/110/111; store other than 000/001/010.
  - Misalignment: word access with addr[1:0] != 0; halfword access with addr[0] = 1.
- IDLE
  - Request with fault: fault = 1 for that cycle, stall = 0, state stays IDLE.
  - Legal request: stall = 1 (combinational), request registers load, next state REQ.
- REQ
  - dmem_read or dmem_write held high; address, wdata and mbe held stable.
  - stall = 1.
  - On dmem_resp: a load latches its extracted dmem_rdata into load_data; next state DONE.
- DONE
  - dmem strobes low, stall = 0, done = 1; the pipeline advances at this edge.
  - Next state is IDLE unconditionally. The held op is never relaunched.
- Byte enables: sb/lb/lbu give 1 << addr[1:0]; sh/lh/lhu give 0011 or 1100 selected by addr[1]; word accesses give 1111. Reads drive dmem_mbe as well.
- Store wdata:
  - sw: store_data unchanged.
  - sh: store_data[15:0] replicated twice.
  - sb: store_data[7:0] replicated four times.
- Load extract:
  - Select the lane given by addr[1:0] (byte) or addr[1] (halfword).
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw is passed through unchanged.
- Stores complete the same way as loads; load_data is left unchanged.
- Watchdog: a counter clears on entry to REQ and increments each REQ cycle. When it reaches TIMEOUT (TIMEOUT > 0), timeout sets and stays set until reset. The FSM continues to wait for dmem_resp.
- dmem_resp in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; stall, done, fault, timeout, dmem_read, dmem_write all 0; dmem_address, dmem_wdata, load_data all 0; dmem_mbe 0000.
- Legal op first seen at cycle 0:
  - Strobes high from cycle 1.
  - dmem_resp at cycle k ≥ 1 gives done at cycle k+1.
  - Minimum occupancy is 3 cycles, with stall high during cycles 0..k.
- Back-to-back ops: the next op is first seen the cycle after DONE, so there is no bubble beyond DONE.
- Reset asserted mid-REQ: all outputs go to reset values immediately and asynchronously. A response arriving after reset release is ignored.
- fault is purely combinational in IDLE and never coincides with stall.

## Test plan
- lw addr 0x100, store_data don't-care, cache returns 0xDEADBEEF after 2 cycles -> dmem_address 0x100, mbe 1111, stall high 3 cycles, done with load_data 0xDEADBEEF.
- lb addr 0x203, rdata 0x80FF_1234 -> mbe 1000, load_data 0xFFFFFF80; lbu at the same address -> 0x00000080; lhu addr 0x202 -> 0x000080FF.
- sb addr 0x301, store_data 0x000000A5 -> dmem_write, mbe 0010, wdata 0xA5A5A5A5, address 0x300; load_data unchanged.
- lw addr 0x102, and separately sh addr 0x101 -> fault = 1 for one cycle, no dmem strobe, stall = 0.
- TIMEOUT = 4, cache never responds -> timeout rises after 4 REQ cycles and stays high; a response on cycle 10 -> done, timeout remains 1.
- Reset pulse during REQ with dmem_resp arriving 1 cycle after release -> state IDLE, no done, load_data 0.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : Data-cache request/response bus between the MEM-stage LSU
//               and the data cache.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_stage_lsu_if;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_resp, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : RV32I MEM-stage load/store unit: legality check, cache
//               handshake with pipeline stall, load extract, response watchdog.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  fault,
  output logic                  timeout,
  mem_stage_lsu_if.master       dmem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_q, load_d;
  logic        timeout_q, timeout_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;

  logic        req;
  logic        bad_op;
  logic [3:0]  mbe_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_c;

  // Request decode: legality, byte enables and lane-replicated store data.
  always_comb begin
    req    = op_valid & (mem_read | mem_write);
    bad_op = 1'b0;
    if (mem_read && mem_write) begin
      bad_op = 1'b1;
    end else if (mem_read) begin
      bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else begin
      bad_op = !(funct3 inside {3'b000, 3'b001, 3'b010});
    end
    if ((funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) ||
        (funct3[1:0] == 2'b01 && addr[0])) begin
      bad_op = 1'b1;
    end

    case (funct3[1:0])
      2'b00: begin
        mbe_c   = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        mbe_c   = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        mbe_c   = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  // Lane select uses the registered offset/funct3 of the op in flight.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = dmem.dmem_rdata[7:0];
      2'd1:    lane_b = dmem.dmem_rdata[15:8];
      2'd2:    lane_b = dmem.dmem_rdata[23:16];
      default: lane_b = dmem.dmem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_c = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext_c = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext_c = {24'd0, lane_b};
      3'b101:  ext_c = {16'd0, lane_h};
      default: ext_c = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mbe_d     = mbe_q;
    f3_d      = f3_q;
    off_d     = off_q;
    load_d    = load_q;
    timeout_d = timeout_q;
    wd_cnt_d  = wd_cnt_q;
    stall     = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad_op) begin
            fault = 1'b1;
          end else begin
            stall    = 1'b1;
            state_d  = S_REQ;
            rd_d     = mem_read;
            wr_d     = mem_write;
            addr_d   = {addr[31:2], 2'b00};
            wdata_d  = wdata_c;
            mbe_d    = mbe_c;
            f3_d     = funct3;
            off_d    = addr[1:0];
            wd_cnt_d = 32'd0;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        // Counter freezes once the sticky flag is set, so it never wraps.
        if (TIMEOUT != 0 && !timeout_q) begin
          wd_cnt_d = wd_cnt_q + 32'd1;
          if (wd_cnt_d == TIMEOUT) begin
            timeout_d = 1'b1;
          end
        end
        if (dmem.dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
          if (rd_q) begin
            load_d = ext_c;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      mbe_q     <= 4'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      load_q    <= 32'd0;
      timeout_q <= 1'b0;
      wd_cnt_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mbe_q     <= mbe_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      load_q    <= load_d;
      timeout_q <= timeout_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign load_data         = load_q;
  assign timeout           = timeout_q;
  assign dmem.dmem_read    = rd_q;
  assign dmem.dmem_write   = wr_q;
  assign dmem.dmem_address = addr_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign dmem.dmem_mbe     = mbe_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: directed vector table,
//               reset/watchdog sequences and randomized ops against a model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

  localparam int TIMEOUT_P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, fault, timeout;
  logic [31:0] load_data;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.TIMEOUT(TIMEOUT_P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .timeout    (timeout),
    .dmem       (dmem_if.master)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic        exp_to    = 1'b0;
  logic [31:0] last_load = 32'd0;

  typedef struct {
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    int          k;
    logic [31:0] rd;
    logic        ef;
    logic [3:0]  em;
    logic [31:0] ew;
    logic [31:0] el;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: size from funct3, alignment by modulo, lanes by shifting.
  task automatic model(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                       output logic ef, output logic [3:0] em,
                       output logic [31:0] ew, output logic [31:0] el);
    int     s, off, m;
    logic   ok;
    longint v;
    s   = 1 << f3[1:0];
    off = int'(a[1:0]);
    ok  = mr ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    ef  = (mr && mw) || !ok || (off % s != 0);
    m   = ((1 << s) - 1) << off;
    em  = m[3:0];
    ew  = 32'd0;
    for (int b = 0; b < 4; b++) ew[8*b +: 8] = sd[8*(b % s) +: 8];
    v = longint'(rd);
    v = v >> (8 * off);
    if (s < 4) begin
      v = v & ((64'd1 << (8 * s)) - 1);
      if (!f3[2] && v >= longint'(64'd1 << (8 * s - 1))) v = v - longint'(64'd1 << (8 * s));
    end
    el = v[31:0];
  endtask

  task automatic run_op(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input int k,
                        input logic [31:0] rd, input logic ef, input logic [3:0] em,
                        input logic [31:0] ew, input logic [31:0] el);
    logic [31:0] exp_ld;
    logic [31:0] junk;
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3;
    addr = a; store_data = sd; dmem_if.dmem_resp = 1'b0;
    @(negedge clk);
    if (ef) begin
      chk({tag, ".fault"}, 32'(fault), 32'd1);
      chk({tag, ".fault_stall"}, 32'(stall), 32'd0);
      chk({tag, ".fault_strobe"}, {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".fault_after"}, {29'd0, dmem_if.dmem_read, dmem_if.dmem_write, fault}, 32'd0);
      return;
    end
    chk({tag, ".c0_fault"}, 32'(fault), 32'd0);
    chk({tag, ".c0_stall"}, 32'(stall), 32'd1);
    chk({tag, ".c0_done"}, 32'(done), 32'd0);
    exp_ld = mr ? el : last_load;
    for (int j = 1; j <= k + 1; j++) begin
      @(posedge clk); #1;
      junk = $urandom;
      dmem_if.dmem_resp  = (j == k);
      dmem_if.dmem_rdata = (j == k) ? rd : junk;
      @(negedge clk);
      if (j - 1 >= TIMEOUT_P) exp_to = 1'b1;
      chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
      if (j <= k) begin
        chk({tag, ".req_stall"}, 32'(stall), 32'd1);
        chk({tag, ".req_done"}, 32'(done), 32'd0);
        chk({tag, ".req_strobe"}, {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, {30'd0, mr, mw});
        chk({tag, ".req_addr"}, dmem_if.dmem_address, {a[31:2], 2'b00});
        chk({tag, ".req_mbe"}, 32'(dmem_if.dmem_mbe), 32'(em));
        if (mw) chk({tag, ".req_wdata"}, dmem_if.dmem_wdata, ew);
        chk({tag, ".req_ld_hold"}, load_data, last_load);
      end else begin
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".done_stall"}, 32'(stall), 32'd0);
        chk({tag, ".done_strobe"}, {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
        chk({tag, ".load_data"}, load_data, exp_ld);
      end
    end
    last_load = exp_ld;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    logic        mr, mw, ef;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd, ew, el, r32;
    logic [3:0]  em;
    int          k, sel, sz;
    logic [2:0]  ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678, 2, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 1, 32'h80FF_1234, 1'b0, 4'h8, 32'h0, 32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 1, 32'h80FF_1234, 1'b0, 4'h8, 32'h0, 32'h0000_0080};
    tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 2, 32'h80FF_1234, 1'b0, 4'hC, 32'h0, 32'h0000_80FF};
    tbl[4]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 1, 32'h0, 1'b0, 4'h2, 32'hA5A5_A5A5, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 3, 32'h80FF_1234, 1'b0, 4'hC, 32'h0, 32'hFFFF_80FF};
    tbl[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 2, 32'h0, 1'b0, 4'hC, 32'hBEEF_BEEF, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 3, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 1, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0};
    tbl[14] = '{1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0, 1, 32'h80FF_1234, 1'b0, 4'h3, 32'h0, 32'h0000_1234};
    tbl[15] = '{1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'h0, 2, 32'h80FF_12F0, 1'b0, 4'h1, 32'h0, 32'hFFFF_FFF0};

    rst_n = 1'b0; op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    dmem_if.dmem_resp = 1'b0; dmem_if.dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    chk("rst.strobes", {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
    chk("rst.addr", dmem_if.dmem_address, 32'd0);
    chk("rst.wdata", dmem_if.dmem_wdata, 32'd0);
    chk("rst.mbe", 32'(dmem_if.dmem_mbe), 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].mr, tbl[i].mw, tbl[i].f3, tbl[i].a, tbl[i].sd,
             tbl[i].k, tbl[i].rd, tbl[i].ef, tbl[i].em, tbl[i].ew, tbl[i].el);

    // Requests without op_valid, or with neither read nor write, do nothing.
    @(posedge clk); #1;
    op_valid = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h104;
    @(negedge clk);
    chk("noop_invalid.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    chk("noop_none.stall", {30'd0, stall, fault}, 32'd0);
    chk("noop_none.strobes", {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);

    // Watchdog: cache silent for 9 REQ cycles, answers on cycle 10.
    run_op("wdog", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 10, 32'h0BAD_F00D,
           1'b0, 4'hF, 32'h0, 32'h0BAD_F00D);
    chk("wdog.sticky", 32'(timeout), 32'd1);

    // Asynchronous reset in the middle of REQ; a late response is ignored.
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0600; dmem_if.dmem_resp = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstreq.pre_strobe", 32'(dmem_if.dmem_read), 32'd1);
    #2;
    rst_n = 1'b0; op_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("rstreq.stall", 32'(stall), 32'd0);
    chk("rstreq.strobe", {30'd0, dmem_if.dmem_read, dmem_if.dmem_write}, 32'd0);
    chk("rstreq.addr", dmem_if.dmem_address, 32'd0);
    chk("rstreq.mbe", 32'(dmem_if.dmem_mbe), 32'd0);
    chk("rstreq.load_data", load_data, 32'd0);
    chk("rstreq.timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_to = 1'b0; last_load = 32'd0;
    @(posedge clk); #1;
    dmem_if.dmem_resp = 1'b1; dmem_if.dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rstreq.resp_stall", 32'(stall), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      dmem_if.dmem_resp = 1'b0;
      @(negedge clk);
      chk("rstreq.no_done", {30'd0, done, stall}, 32'd0);
      chk("rstreq.ld_zero", load_data, 32'd0);
    end

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      mr = 1'b0; mw = 1'b0;
      r32 = $urandom;
      if (sel < 5) begin
        mr = 1'b1; f3 = ld_f3[$urandom_range(0, 4)];
      end else if (sel < 8) begin
        mw = 1'b1; f3 = 3'($urandom_range(0, 2));
      end else if (sel == 8) begin
        mr = r32[31]; mw = !r32[31]; f3 = r32[30:28];
      end else begin
        mr = 1'b1; mw = 1'b1; f3 = 3'($urandom_range(0, 2));
      end
      a = $urandom;
      sz = 1 << f3[1:0];
      if (r32[0]) a = a - (a % sz);
      sd = $urandom;
      rd = $urandom;
      k  = $urandom_range(1, 5);
      model(mr, mw, f3, a, sd, rd, ef, em, ew, el);
      run_op($sformatf("rnd%0d", n), mr, mw, f3, a, sd, k, rd, ef, em, ew, el);
    end

    @(posedge clk); #1;
    op_valid = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
